// File: rtl/mul_arbiter_pkg.sv
// mul_arbiter_pkg: shared types and default widths for the multiplier arbiter.
//   state_t     : arbiter FSM encoding (IDLE -> ISSUE -> WAIT -> DELIVER)
//   DEF_*       : default requester count and operand widths
package mul_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_A_WIDTH = 32;
    localparam int DEF_B_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

endpackage

// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if: bundles the requester-side and multiplier-side STB/ACK buses.
//   REQ_I_*  : per-requester operand port (STB/ACK, packed operands)
//   REQ_O_*  : per-requester result port (STB/ACK, shared result data)
//   M_I_*    : operand port towards the shared multiplier
//   M_O_*    : result port from the shared multiplier
// Modports: slave = arbiter view, master = environment (clients + multiplier) view.
interface mul_arbiter_if
    import mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int B_WIDTH = DEF_B_WIDTH
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic [NUM_REQ-1:0]         REQ_I_STB;
    logic [NUM_REQ-1:0]         REQ_I_ACK;
    logic [NUM_REQ*A_WIDTH-1:0] REQ_I_DAT_A;
    logic [NUM_REQ*B_WIDTH-1:0] REQ_I_DAT_B;
    logic [NUM_REQ-1:0]         REQ_O_STB;
    logic [P_WIDTH-1:0]         REQ_O_DAT;
    logic [NUM_REQ-1:0]         REQ_O_ACK;
    logic                       M_I_STB;
    logic                       M_I_ACK;
    logic [A_WIDTH-1:0]         M_I_DAT_A;
    logic [B_WIDTH-1:0]         M_I_DAT_B;
    logic                       M_O_STB;
    logic [P_WIDTH-1:0]         M_O_DAT;
    logic                       M_O_ACK;

    modport slave (
        input  REQ_I_STB, REQ_I_DAT_A, REQ_I_DAT_B, REQ_O_ACK,
        input  M_I_ACK, M_O_STB, M_O_DAT,
        output REQ_I_ACK, REQ_O_STB, REQ_O_DAT,
        output M_I_STB, M_I_DAT_A, M_I_DAT_B, M_O_ACK
    );

    modport master (
        output REQ_I_STB, REQ_I_DAT_A, REQ_I_DAT_B, REQ_O_ACK,
        output M_I_ACK, M_O_STB, M_O_DAT,
        input  REQ_I_ACK, REQ_O_STB, REQ_O_DAT,
        input  M_I_STB, M_I_DAT_A, M_I_DAT_B, M_O_ACK
    );

endinterface

// File: rtl/mul_arbiter_rr_arbiter.sv
// mul_arbiter_rr_arbiter: combinational round-robin pick.
//   req_i       : request vector
//   ptr_i       : highest-priority index this round
//   gnt_idx_o   : first requester at or after ptr_i, wrapping
//   gnt_valid_o : any request present
module mul_arbiter_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    logic [NUM_REQ-1:0]   mask;
    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;

    // Lower copy keeps only requests at or above the pointer; the upper copy
    // supplies the wrapped-around candidates, so a plain lowest-bit search works.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            mask[i] = (i >= 32'(ptr_i));
        end
        dbl         = {req_i, req_i & mask};
        found       = 1'b0;
        gnt_idx_o   = '0;
        gnt_valid_o = |req_i;
        for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found && dbl[i]) begin
                found     = 1'b1;
                gnt_idx_o = IDX_W'(i % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one STB/ACK multiplier among NUM_REQ requesters,
// round-robin, one operation in flight, result routed back to its issuer.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   bus        : requester and multiplier buses (mul_arbiter_if.slave)
//   BUSY       : high whenever the FSM is not IDLE
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int A_WIDTH = DEF_A_WIDTH,
    parameter int B_WIDTH = DEF_B_WIDTH
) (
    input  logic            CLK,
    input  logic            RST_N,
    mul_arbiter_if.slave    bus,
    output logic            BUSY
);

    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [IDX_W-1:0]   gnt_q,   gnt_d;
    logic [A_WIDTH-1:0] op_a_q,  op_a_d;
    logic [B_WIDTH-1:0] op_b_q,  op_b_d;
    logic [P_WIDTH-1:0] res_q,   res_d;

    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    mul_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i       (bus.REQ_I_STB),
        .ptr_i       (ptr_q),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d = arb_idx;
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        if (arb_idx == IDX_W'(k)) begin
                            op_a_d = bus.REQ_I_DAT_A[k*A_WIDTH +: A_WIDTH];
                            op_b_d = bus.REQ_I_DAT_B[k*B_WIDTH +: B_WIDTH];
                        end
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.M_I_ACK) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.M_O_STB) begin
                    res_d   = bus.M_O_DAT;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                // Only the owner's ack retires the result; the served
                // requester becomes lowest priority for the next pick.
                if (bus.REQ_O_ACK[gnt_q]) begin
                    ptr_d   = (gnt_q == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.REQ_I_ACK = '0;
        bus.REQ_O_STB = '0;
        bus.M_I_STB   = 1'b0;
        bus.M_O_ACK   = 1'b0;
        BUSY          = (state_q != IDLE);
        case (state_q)
            // Gated by RST_N so no accept is signalled while reset holds IDLE.
            IDLE:    if (arb_valid && RST_N) bus.REQ_I_ACK[arb_idx] = 1'b1;
            ISSUE:   bus.M_I_STB = 1'b1;
            WAIT:    bus.M_O_ACK = 1'b1;
            DELIVER: bus.REQ_O_STB[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    assign bus.M_I_DAT_A = op_a_q;
    assign bus.M_I_DAT_B = op_b_q;
    assign bus.REQ_O_DAT = res_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard bench for mul_arbiter with a behavioural
// zero-wait multiplier whose operand accept and result strobe can be stalled.
module tb_mul_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int BW = 32;
    localparam int PW = AW + BW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    mul_arbiter_if #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW)) bus ();

    mul_arbiter #(.NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus),
        .BUSY  (busy)
    );

    // Stimulus state
    logic [NR-1:0] req_stb;
    logic [AW-1:0] a_v [NR];
    logic [BW-1:0] b_v [NR];
    logic          auto_ack;
    logic [NR-1:0] man_ack;
    logic          mul_ready;
    logic          mul_hold;
    logic          mul_pend;
    logic [PW-1:0] mul_prod;

    always_comb begin
        bus.REQ_I_DAT_A = '0;
        bus.REQ_I_DAT_B = '0;
        for (int k = 0; k < NR; k++) begin
            bus.REQ_I_DAT_A[k*AW +: AW] = a_v[k];
            bus.REQ_I_DAT_B[k*BW +: BW] = b_v[k];
        end
    end

    assign bus.REQ_I_STB = req_stb;
    assign bus.REQ_O_ACK = auto_ack ? bus.REQ_O_STB : man_ack;
    assign bus.M_I_ACK   = bus.M_I_STB & mul_ready;
    assign bus.M_O_STB   = mul_pend & ~mul_hold;
    assign bus.M_O_DAT   = mul_prod;

    // Behavioural multiplier, reset from the same source as the arbiter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_pend <= 1'b0;
            mul_prod <= '0;
        end else if (bus.M_I_STB && bus.M_I_ACK) begin
            mul_pend <= 1'b1;
            mul_prod <= PW'(bus.M_I_DAT_A) * PW'(bus.M_I_DAT_B);
        end else if (bus.M_O_STB && bus.M_O_ACK) begin
            mul_pend <= 1'b0;
        end
    end

    // Scoreboard
    typedef struct {
        int unsigned   idx;
        logic [PW-1:0] prod;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int unsigned grant_log[$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.REQ_I_ACK != '0) begin
                chk("iack_onehot", 64'($onehot(bus.REQ_I_ACK)), 64'd1);
                for (int k = 0; k < NR; k++) begin
                    if (bus.REQ_I_ACK[k]) begin
                        exp_q.push_back('{idx: k, prod: PW'(a_v[k]) * PW'(b_v[k])});
                        grant_log.push_back(k);
                    end
                end
            end
            if ((bus.REQ_O_STB & bus.REQ_O_ACK) != '0) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("ostb_owner", 64'(bus.REQ_O_STB), 64'(1) << e.idx);
                    chk("odat", bus.REQ_O_DAT, e.prod);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ostb(input int maxc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.REQ_O_STB != '0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("wait_ostb", 64'(bus.REQ_O_STB != '0), 64'd1);
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_sb", 64'(exp_q.size()), 64'd0);
    endtask

    // One isolated operation with a known expected product and manual ack
    task automatic run_one(input int k, input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic [PW-1:0] want, input string tag);
        auto_ack = 1'b0;
        a_v[k] = a;
        b_v[k] = b;
        tick();
        req_stb = NR'(1) << k;
        tick();
        req_stb = '0;
        wait_ostb(20);
        chk(tag, bus.REQ_O_DAT, want);
        tick();
        man_ack = NR'(1) << k;
        tick();
        man_ack = '0;
        wait_idle(20);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned want_order[5];
        want_order = '{0, 1, 2, 3, 0};
        req_stb   = '1;
        auto_ack  = 1'b1;
        man_ack   = '0;
        mul_ready = 1'b1;
        mul_hold  = 1'b0;
        for (int k = 0; k < NR; k++) begin
            a_v[k] = '0;
            b_v[k] = '0;
        end

        // Reset state, with every requester asserting
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ostb", 64'(bus.REQ_O_STB), 64'd0);
        chk("rst_mistb", 64'(bus.M_I_STB), 64'd0);
        chk("rst_moack", 64'(bus.M_O_ACK), 64'd0);
        chk("rst_iack", 64'(bus.REQ_I_ACK), 64'd0);
        req_stb = '0;
        tick();
        rst_n = 1'b1;

        // All four requesting continuously: strict rotation from pointer 0
        for (int k = 0; k < NR; k++) begin
            a_v[k] = $urandom;
            b_v[k] = $urandom;
        end
        grant_log.delete();
        tick();
        req_stb = '1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (grant_log.size() >= 5) break;
        end
        req_stb = '0;
        wait_idle(40);
        chk("rr_count", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_order", 64'(grant_log[i]), 64'(want_order[i]));
        end

        // Single request 7*6, cycle-accurate latency
        auto_ack = 1'b0;
        a_v[1] = 32'd7;
        b_v[1] = 32'd6;
        tick();
        req_stb = 4'b0010;
        @(negedge clk);
        chk("t1_iack", 64'(bus.REQ_I_ACK), 64'b0010);
        tick();
        req_stb = '0;
        @(negedge clk);
        chk("t1_mistb", 64'(bus.M_I_STB), 64'd1);
        chk("t1_opa", 64'(bus.M_I_DAT_A), 64'd7);
        chk("t1_opb", 64'(bus.M_I_DAT_B), 64'd6);
        chk("t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_moack", 64'(bus.M_O_ACK), 64'd1);
        chk("t1_ostb_early", 64'(bus.REQ_O_STB), 64'd0);
        @(negedge clk);
        chk("t1_ostb", 64'(bus.REQ_O_STB), 64'b0010);
        chk("t1_dat", bus.REQ_O_DAT, 64'd42);
        tick();
        man_ack = 4'b0010;
        tick();
        man_ack = '0;
        wait_idle(20);

        // Back-pressure on the multiplier operand port, then on the result port
        mul_ready = 1'b0;
        a_v[3] = 32'h1234_5678;
        b_v[3] = 32'h0000_0100;
        tick();
        req_stb = 4'b1000;
        tick();
        req_stb = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_mistb", 64'(bus.M_I_STB), 64'd1);
            chk("bp_opa", 64'(bus.M_I_DAT_A), 64'(a_v[3]));
            chk("bp_opb", 64'(bus.M_I_DAT_B), 64'(b_v[3]));
            chk("bp_iack", 64'(bus.REQ_I_ACK), 64'd0);
        end
        tick();
        mul_ready = 1'b1;
        wait_ostb(20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_ostb", 64'(bus.REQ_O_STB), 64'b1000);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        tick();
        req_stb = '0;
        man_ack = 4'b1000;
        tick();
        man_ack = '0;
        wait_idle(20);

        // Width extremes
        run_one(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_prod");
        run_one(1, 32'h0000_0000, 32'hFFFF_FFFF, 64'd0, "zero_prod");

        // Ack from a non-owner is ignored
        auto_ack = 1'b0;
        a_v[2] = 32'd9;
        b_v[2] = 32'd11;
        tick();
        req_stb = 4'b0100;
        tick();
        req_stb = '0;
        wait_ostb(20);
        tick();
        man_ack = 4'b0001;
        tick();
        man_ack = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wrong_ack_ostb", 64'(bus.REQ_O_STB), 64'b0100);
            chk("wrong_ack_dat", bus.REQ_O_DAT, 64'd99);
        end
        tick();
        man_ack = 4'b0100;
        tick();
        man_ack = '0;
        wait_idle(20);

        // Reset while waiting on the multiplier
        mul_hold = 1'b1;
        a_v[1] = 32'd5;
        b_v[1] = 32'd5;
        tick();
        req_stb = 4'b0010;
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.M_O_ACK) break;
        end
        chk("t6_in_wait", 64'(bus.M_O_ACK), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ostb", 64'(bus.REQ_O_STB), 64'd0);
        chk("t6_mistb", 64'(bus.M_I_STB), 64'd0);
        chk("t6_moack", 64'(bus.M_O_ACK), 64'd0);
        chk("t6_iack", 64'(bus.REQ_I_ACK), 64'd0);
        exp_q.delete();
        req_stb  = '0;
        mul_hold = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        req_stb = 4'b1001;
        @(negedge clk);
        chk("t6_first_grant", 64'(bus.REQ_I_ACK), 64'b0001);
        tick();
        req_stb  = '0;
        auto_ack = 1'b1;
        wait_idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
